// File: rtl/gf_clmul_seq.sv
// Sequential shift-and-add carry-less multiplier producing the unreduced GF(2)[x] product.
// Define CLMUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module gf_clmul_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        op_enable,
    input  logic [$clog2(DATA_WIDTH):0] polyn_grade,
    input  logic [DATA_WIDTH-1:0]       op_a,
    input  logic [DATA_WIDTH-1:0]       op_b,
    output logic [2*DATA_WIDTH-1:0]     out,
    output logic                        op_finish
);

    localparam int GW = $clog2(DATA_WIDTH) + 1;
    localparam logic [GW-1:0] MAX_GRADE = GW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state, next_state;
    logic [GW-1:0]           grade_eff;
    logic [GW-1:0]           grade_reg, grade_next;
    logic [GW-1:0]           cnt, cnt_next, cnt_inc;
    logic [DATA_WIDTH-1:0]   op_mask;
    logic [DATA_WIDTH-1:0]   b_reg, b_next, b_shift;
    logic [2*DATA_WIDTH-1:0] a_reg, a_next;
    logic [2*DATA_WIDTH-1:0] acc, acc_next;
    logic                    last_iter;

    // A grade of zero or one beyond the datapath means "use the full width".
    always_comb begin
        grade_eff = polyn_grade;
        if (polyn_grade == '0 || polyn_grade > MAX_GRADE) begin
            grade_eff = MAX_GRADE;
        end
    end

    always_comb begin
        op_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            op_mask[i] = (GW'(i) < grade_eff);
        end
    end

    assign b_shift = b_reg >> 1;
    assign cnt_inc = cnt + GW'(1);

`ifdef CLMUL_EARLY_EXIT_EN
    assign last_iter = (cnt_inc == grade_reg) || (b_shift == '0);
`else
    assign last_iter = (cnt_inc == grade_reg);
`endif

    always_comb begin
        next_state = state;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc;
        cnt_next   = cnt;
        grade_next = grade_reg;
        case (state)
            IDLE: begin
                if (op_enable) begin
                    a_next     = {{DATA_WIDTH{1'b0}}, op_a & op_mask};
                    b_next     = op_b & op_mask;
                    acc_next   = '0;
                    cnt_next   = '0;
                    grade_next = grade_eff;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!op_enable) begin
                    next_state = IDLE;
                end else begin
                    if (b_reg[0]) begin
                        acc_next = acc ^ a_reg;
                    end
                    a_next   = a_reg << 1;
                    b_next   = b_shift;
                    cnt_next = cnt_inc;
                    if (last_iter) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (!op_enable) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // op_finish is registered from the next state so it rises with the DONE state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            grade_reg <= '0;
            op_finish <= 1'b0;
        end else begin
            state     <= next_state;
            a_reg     <= a_next;
            b_reg     <= b_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            grade_reg <= grade_next;
            op_finish <= (next_state == DONE);
        end
    end

    assign out = acc;

endmodule

// File: tb/tb_gf_clmul_seq.sv
// Scoreboard bench for gf_clmul_seq: stimulus pushes reference results, a monitor checks each finish.
module tb_gf_clmul_seq;

    localparam int W  = 8;
    localparam int GW = $clog2(W) + 1;

    logic              clk;
    logic              rst_n;
    logic              op_enable;
    logic [GW-1:0]     polyn_grade;
    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic [2*W-1:0]    out;
    logic              op_finish;

    gf_clmul_seq #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_enable   (op_enable),
        .polyn_grade (polyn_grade),
        .op_a        (op_a),
        .op_b        (op_b),
        .out         (out),
        .op_finish   (op_finish)
    );

    typedef struct {
        logic [2*W-1:0] prod;
        int             lat;
        int             cap;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    int             errors = 0;
    int             checks = 0;
    int             cycle  = 0;
    logic           prev_fin = 1'b0;
    logic [2*W-1:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle = cycle + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic int eff_grade(input int pg);
        return (pg == 0 || pg > W) ? W : pg;
    endfunction

    // Carry-less product as a sum (over GF(2)) of shifted copies of a, operands truncated to g bits.
    function automatic logic [2*W-1:0] ref_product(input int pg, input int a, input int b);
        int g, ma, mb, res;
        g   = eff_grade(pg);
        ma  = a % (1 << g);
        mb  = b % (1 << g);
        res = 0;
        for (int i = 0; i < W; i++) begin
            if (((mb >> i) & 1) == 1) res = res ^ (ma << i);
        end
        return res[2*W-1:0];
    endfunction

    function automatic int ref_latency(input int pg, input int b);
        int g, mb, lat;
        g  = eff_grade(pg);
        mb = b % (1 << g);
`ifdef CLMUL_EARLY_EXIT_EN
        lat = 1;
        for (int i = 0; i < W; i++) begin
            if (((mb >> i) & 1) == 1) lat = i + 1;
        end
`else
        lat = g;
`endif
        return lat;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_fin = 1'b0;
        end else begin
            if (op_finish && !prev_fin) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_finish", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("product", 32'(out), 32'(mon_e.prod));
                    check_output("latency", 32'(cycle - mon_e.cap), 32'(mon_e.lat));
                end
                held = out;
            end else if (op_finish) begin
                check_output("done_stable", 32'(out), 32'(held));
            end
            prev_fin = op_finish;
        end
    end

    // Called on a falling edge; returns on a falling edge with op_enable low again.
    task automatic apply_stimulus(input int pg, input int a, input int b, input int hold);
        exp_t e;
        bit   seen;
        polyn_grade = GW'(pg);
        op_a        = W'(a);
        op_b        = W'(b);
        op_enable   = 1'b1;
        e.prod = ref_product(pg, a, b);
        e.lat  = ref_latency(pg, b);
        e.cap  = cycle + 1;
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(negedge clk);
            polyn_grade = GW'($urandom_range(0, 15));
            op_a        = W'($urandom);
            op_b        = W'($urandom);
            if (op_finish) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check_output("finish_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_back());
        end
        for (int i = 0; i < hold; i++) @(negedge clk);
        op_enable = 1'b0;
        @(posedge clk);
        #1;
        check_output("finish_drop", 32'(op_finish), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b1;
        op_enable   = 1'b0;
        polyn_grade = '0;
        op_a        = '0;
        op_b        = '0;
        #1 rst_n = 1'b0;
        #1;
        check_output("reset_out", 32'(out), 32'd0);
        check_output("reset_finish", 32'(op_finish), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        apply_stimulus(4, 'h05, 'h03, 2);
        apply_stimulus(8, 'hFF, 'hFF, 1);
        apply_stimulus(3, 'h1D, 'h07, 0);
        apply_stimulus(8, 'hA7, 'h01, 1);
        apply_stimulus(0, 'h80, 'h80, 0);
        apply_stimulus(8, 'h5A, 'h00, 0);

        // Abort after two RUN edges: no finish may follow.
        polyn_grade = GW'(4);
        op_a        = W'(5);
        op_b        = W'(3);
        op_enable   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        op_enable = 1'b0;
        repeat (8) @(negedge clk);
        check_output("abort_finish", 32'(op_finish), 32'd0);
        apply_stimulus(4, 5, 3, 1);

        // Asynchronous reset in the middle of a long operation.
        polyn_grade = GW'(8);
        op_a        = W'('hFF);
        op_b        = W'('hFF);
        op_enable   = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrun_reset_out", 32'(out), 32'd0);
        check_output("midrun_reset_finish", 32'(op_finish), 32'd0);
        op_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(8, 'hA7, 'h01, 0);

        for (int n = 0; n < 40; n++) begin
            apply_stimulus($urandom_range(0, 15), $urandom_range(0, 255),
                           $urandom_range(0, 255), $urandom_range(0, 3));
        end

        repeat (4) @(negedge clk);
        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
